// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its neighbours.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } if_state_e;

    // Word presented in the instruction slot alongside an address fault.
    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;

    // Word-aligned and inside [0, limit). Zero-extend narrower addresses.
    // The data-memory stage calls this as well.
    function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] limit);
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/instr_fetch_slot.sv
// Generic valid/ready pipeline register with a flush input.
// Priority: flush empties it, then load overwrites it, then a transfer
// empties it. in_ready reports when an ordinary load does not lose a word.
module instr_fetch_slot #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Next-state of the slot from flush, load and the downstream handshake.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; reset leaves it empty with zeroed contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, addresses the ROM (read on negedge),
// captures the word on the next posedge and hands {pc, instr} to decode.
// Redirects flush the slot; illegal addresses produce a sticky fault marker.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          N         = 32,
    parameter int          SIZE      = 1024,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [N-1:0] NOP_INSTR = N'(IF_NOP_INSTR)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] rom_addr,
    input  logic [N-1:0] rom_data,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         if_valid,
    input  logic         if_ready,
    output logic [N-1:0] if_pc,
    output logic [N-1:0] if_instr,
    output logic         if_fault
);

    localparam int          SW         = 2 * N + 1;
    localparam logic [63:0] BYTE_LIMIT = 64'(SIZE) * 64'd4;

    if_state_e state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    // Set when pc_q+4 carried out of N bits; the wrapped pc must not fetch.
    logic         pc_ovf_q, pc_ovf_d;
    logic [N:0]   pc_inc;
    logic         pc_legal, redirect_legal;
    logic         slot_flush, slot_load, slot_in_ready;
    logic [SW-1:0] slot_in, slot_out;

    assign pc_inc         = {1'b0, pc_q} + (N + 1)'(4);
    assign pc_legal       = addr_legal(64'(pc_q), BYTE_LIMIT) && !pc_ovf_q;
    assign redirect_legal = addr_legal(64'(redirect_pc), BYTE_LIMIT);

    // Fetch control: redirect beats load beats stall; FAULT keeps re-presenting its marker.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_ovf_d   = pc_ovf_q;
        slot_flush = 1'b0;
        slot_load  = 1'b0;
        slot_in    = slot_out;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (redirect_valid) begin
                    pc_d     = redirect_pc;
                    pc_ovf_d = 1'b0;
                end
            end
            default: begin
                if (redirect_valid) begin
                    pc_d     = redirect_pc;
                    pc_ovf_d = 1'b0;
                    if (redirect_legal) begin
                        slot_flush = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        slot_load = 1'b1;
                        slot_in   = {redirect_pc, NOP_INSTR, 1'b1};
                        state_d   = ST_FAULT;
                    end
                end else if (state_q == ST_FAULT) begin
                    slot_load = 1'b1;
                end else if (slot_in_ready) begin
                    slot_load = 1'b1;
                    if (pc_legal) begin
                        slot_in  = {pc_q, rom_data, 1'b0};
                        pc_d     = pc_inc[N-1:0];
                        pc_ovf_d = pc_ovf_q | pc_inc[N];
                    end else begin
                        slot_in = {pc_q, NOP_INSTR, 1'b1};
                        state_d = ST_FAULT;
                    end
                end
            end
        endcase
    end

    // State and program counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            pc_ovf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_ovf_q <= pc_ovf_d;
        end
    end

    instr_fetch_slot #(
        .W (SW)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .flush     (slot_flush),
        .load      (slot_load),
        .in_data   (slot_in),
        .in_ready  (slot_in_ready),
        .out_valid (if_valid),
        .out_ready (if_ready),
        .out_data  (slot_out)
    );

    assign rom_addr = pc_q;
    assign if_pc    = slot_out[2*N:N+1];
    assign if_instr = slot_out[N:1];
    assign if_fault = slot_out[0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then randomized traffic.
// Expected transfers come from a stream model: after reset or a redirect to
// address T, decode must receive T, T+4, ... while legal, then the fault
// marker for the first illegal address, repeated forever.
module tb_instr_fetch;

    localparam int          SIZE  = 1024;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_fault       (if_fault)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [SIZE];

    // ROM: samples the address on the falling edge.
    always @(negedge clk)
        rom_data <= (rom_addr < 32'(SIZE * 4)) ? mem[rom_addr[11:2]] : 32'hDEAD_BEEF;

    typedef struct {
        bit          tok;
        logic [31:0] pc;
        logic [31:0] instr;
        bit          fault;
    } item_t;

    item_t             q[$];
    longint unsigned   gen_addr;
    int                n_cmp  = 0;
    int                n_fail = 0;
    int                n_xfer = 0;
    bit                in_rst = 1'b0;
    bit                prev_hold = 1'b0;
    logic [31:0]       prev_pc, prev_instr;
    logic              prev_fault;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic gen_push();
        item_t it;
        it.tok = 1'b0;
        it.pc  = gen_addr[31:0];
        if ((gen_addr % 4 == 0) && (gen_addr < 64'(SIZE * 4))) begin
            it.instr  = mem[int'(gen_addr / 4)];
            it.fault  = 1'b0;
            gen_addr += 4;
        end else begin
            it.instr = NOP;
            it.fault = 1'b1;
        end
        q.push_back(it);
    endtask

    // A new stream begins: token marks where the monitor resumes after the flush.
    task automatic push_token(input logic [31:0] target);
        item_t t;
        t.tok   = 1'b1;
        t.pc    = target;
        t.instr = '0;
        t.fault = 1'b0;
        q.push_back(t);
        gen_addr = 64'(target);
        repeat (8) gen_push();
    endtask

    task automatic top_up();
        while (q.size() < 8) gen_push();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        top_up();
    endtask

    task automatic flush_q();
        item_t it;
        bit found = 1'b0;
        while (q.size() > 0 && !found) begin
            it = q.pop_front();
            found = it.tok;
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL flush_token: got none expected token at %0t", $time);
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(0, 4))
            0: t = 32'($urandom_range(0, SIZE - 1)) << 2;
            1: t = 32'($urandom_range(SIZE - 4, SIZE - 1)) << 2;
            2: t = (32'($urandom_range(0, SIZE - 1)) << 2) | 32'($urandom_range(1, 3));
            3: t = 32'(SIZE * 4) + (32'($urandom_range(0, 255)) << 2);
            default: t = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'h0000_0010;
        endcase
        return t;
    endfunction

    // Monitor: compares every transfer against the scoreboard and checks slot stability under stall.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!in_rst) flush_q();
                in_rst    = 1'b1;
                prev_hold = 1'b0;
                continue;
            end
            in_rst = 1'b0;
            if (prev_hold) begin
                chk("stall_valid", if_valid, 1);
                chk("stall_pc", if_pc, prev_pc);
                chk("stall_instr", if_instr, prev_instr);
                chk("stall_fault", if_fault, prev_fault);
            end
            if (if_valid && if_ready) begin
                n_xfer++;
                if (q.size() == 0 || q[0].tok) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL xfer_unexpected: got pc %h with no expected item at %0t", if_pc, $time);
                end else begin
                    it = q.pop_front();
                    chk("xfer_pc", if_pc, it.pc);
                    chk("xfer_instr", if_instr, it.instr);
                    chk("xfer_fault", if_fault, it.fault);
                end
            end
            if (redirect_valid) flush_q();
            prev_hold  = if_valid && !if_ready && !redirect_valid;
            prev_pc    = if_pc;
            prev_instr = if_instr;
            prev_fault = if_fault;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios, then randomized redirects, stalls and resets.
    initial begin
        logic [31:0] tgt;
        for (int i = 0; i < SIZE; i++) mem[i] = $urandom;
        mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2; mem[3] = 32'hA3;

        push_token(RST_PC);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", if_valid, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_fault", if_fault, 0);
        chk("rst_rom_addr", rom_addr, RST_PC);

        tick(); rst = 1'b0;
        tick(); chk("boot_valid", if_valid, 0);
        tick(); chk("f0_pc", if_pc, 32'h0); chk("f0_instr", if_instr, 32'hA0);
        tick(); chk("f1_pc", if_pc, 32'h4); chk("f1_instr", if_instr, 32'hA1);
        tick(); chk("f2_pc", if_pc, 32'h8); chk("f2_instr", if_instr, 32'hA2);
        if_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("hold_pc", if_pc, 32'h8);
            chk("hold_instr", if_instr, 32'hA2);
            chk("hold_rom_addr", rom_addr, 32'hC);
        end
        if_ready = 1'b1;
        tick(); chk("f3_pc", if_pc, 32'hC); chk("f3_instr", if_instr, 32'hA3);

        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; push_token(32'h40);
        tick(); redirect_valid = 1'b0; if_ready = 1'b1;
        chk("redir_empty", if_valid, 0);
        tick(); chk("redir_pc", if_pc, 32'h40); chk("redir_instr", if_instr, mem[16]);

        redirect_valid = 1'b1; redirect_pc = 32'h42; push_token(32'h42);
        tick(); redirect_valid = 1'b0;
        repeat (3) begin
            chk("flt_valid", if_valid, 1);
            chk("flt_fault", if_fault, 1);
            chk("flt_pc", if_pc, 32'h42);
            chk("flt_instr", if_instr, NOP);
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0; push_token(32'h0);
        tick(); redirect_valid = 1'b0;
        chk("unflt_empty", if_valid, 0);
        tick(); chk("unflt_pc", if_pc, 32'h0); chk("unflt_instr", if_instr, mem[0]);

        redirect_valid = 1'b1; redirect_pc = 32'hFFC; push_token(32'hFFC);
        tick(); redirect_valid = 1'b0;
        tick(); chk("last_pc", if_pc, 32'hFFC); chk("last_instr", if_instr, mem[1023]);
        chk("last_fault", if_fault, 0);
        tick(); chk("end_pc", if_pc, 32'h1000); chk("end_fault", if_fault, 1);
        chk("end_instr", if_instr, NOP);

        redirect_valid = 1'b1; redirect_pc = 32'h100; push_token(32'h100);
        tick(); redirect_valid = 1'b0;
        tick(); if_ready = 1'b0;
        tick(); chk("pre_rst_valid", if_valid, 1);
        rst = 1'b1; push_token(RST_PC);
        #1;
        chk("arst_valid", if_valid, 0);
        chk("arst_pc", if_pc, 0);
        chk("arst_instr", if_instr, 0);
        chk("arst_rom_addr", rom_addr, RST_PC);
        tick(); rst = 1'b0; if_ready = 1'b1;
        tick(); chk("reboot_valid", if_valid, 0);
        tick(); chk("reboot_pc", if_pc, RST_PC); chk("reboot_instr", if_instr, mem[0]);

        for (int c = 0; c < 3000; c++) begin
            if_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = 1'b0;
            case ($urandom_range(0, 199))
                0: begin
                    rst = 1'b1;
                    push_token(RST_PC);
                    tick();
                    rst = 1'b0;
                end
                1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12: begin
                    tgt            = pick_target();
                    redirect_valid = 1'b1;
                    redirect_pc    = tgt;
                    push_token(tgt);
                end
                default: ;
            endcase
            tick();
        end
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        repeat (4) tick();
        chk("xfer_count_ok", 32'(n_xfer > 1000), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
